// File: rtl/window_3x3_linebuf_pkg.sv
// window_3x3_linebuf_pkg: image geometry and pixel type shared by the window generator and the 3x3 kernels.
package window_3x3_linebuf_pkg;
    localparam int DEF_IMG_W = 64;
    localparam int DEF_IMG_H = 64;
    localparam int DEF_PIX_W = 13;
    localparam int DEF_CW    = 7;
    typedef logic [DEF_PIX_W-1:0] pix_t;
endpackage

// File: rtl/window_3x3_linebuf_line_delay.sv
// window_3x3_linebuf_line_delay: enable-gated delay line of DEPTH samples built on a circular RAM.
module window_3x3_linebuf_line_delay #(
    parameter int DEPTH = 64,
    parameter int W     = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] ptr_q, ptr_d;
    // The slot about to be overwritten holds the sample from exactly DEPTH enables ago.
    assign q_o = mem[ptr_q];
    always_comb ptr_d = (ptr_q == AW'(DEPTH-1)) ? '0 : ptr_q + AW'(1);
    always_ff @(posedge clk) begin
        if (rst)
            ptr_q <= '0;
        else if (en_i)
            ptr_q <= ptr_d;
    end
    always_ff @(posedge clk) begin
        if (en_i)
            mem[ptr_q] <= d_i;
    end
endmodule

// File: rtl/window_3x3_linebuf.sv
// window_3x3_linebuf: streaming 3x3 neighbourhood generator over two line buffers, interior windows only.
module window_3x3_linebuf
    import window_3x3_linebuf_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int PIX_W = DEF_PIX_W,
    parameter int CW    = DEF_CW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_data,
    output logic [PIX_W-1:0] p0,
    output logic [PIX_W-1:0] p1,
    output logic [PIX_W-1:0] p2,
    output logic [PIX_W-1:0] p3,
    output logic [PIX_W-1:0] p4,
    output logic [PIX_W-1:0] p5,
    output logic [PIX_W-1:0] p6,
    output logic [PIX_W-1:0] p7,
    output logic [PIX_W-1:0] p8,
    output logic             win_valid,
    output logic [CW-1:0]    out_x,
    output logic [CW-1:0]    out_y,
    output logic             frame_done
);
    logic [CW-1:0]    col_q, row_q, col_pos, row_pos, col_d, row_d;
    logic             col_last, row_last, emit;
    logic [PIX_W-1:0] lb1_q, lb0_q;
    logic [PIX_W-1:0] top_q [2];
    logic [PIX_W-1:0] mid_q [2];
    logic [PIX_W-1:0] bot_q [2];

    window_3x3_linebuf_line_delay #(.DEPTH(IMG_W), .W(PIX_W)) u_lb1 (
        .clk(clk), .rst(rst), .en_i(in_valid), .d_i(in_data), .q_o(lb1_q)
    );
    window_3x3_linebuf_line_delay #(.DEPTH(IMG_W), .W(PIX_W)) u_lb0 (
        .clk(clk), .rst(rst), .en_i(in_valid), .d_i(lb1_q), .q_o(lb0_q)
    );

    // A start-of-frame pixel is placed at (0,0) whatever the counters say.
    always_comb begin
        col_pos  = in_sof ? '0 : col_q;
        row_pos  = in_sof ? '0 : row_q;
        col_last = col_pos == CW'(IMG_W-1);
        row_last = row_pos == CW'(IMG_H-1);
        col_d    = col_last ? '0 : col_pos + CW'(1);
        row_d    = col_last ? (row_last ? '0 : row_pos + CW'(1)) : row_pos;
        emit     = in_valid && row_pos >= CW'(2) && col_pos >= CW'(2);
    end

    // Each row keeps its two older columns; the newest column is the live tap this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            {p0, p1, p2, p3, p4, p5, p6, p7, p8} <= '0;
            top_q      <= '{default: '0};
            mid_q      <= '{default: '0};
            bot_q      <= '{default: '0};
        end else begin
            win_valid  <= emit;
            frame_done <= emit && col_last && row_last;
            if (in_valid) begin
                col_q    <= col_d;
                row_q    <= row_d;
                top_q[0] <= top_q[1];
                top_q[1] <= lb0_q;
                mid_q[0] <= mid_q[1];
                mid_q[1] <= lb1_q;
                bot_q[0] <= bot_q[1];
                bot_q[1] <= in_data;
            end
            if (emit) begin
                p0    <= top_q[0];
                p1    <= top_q[1];
                p2    <= lb0_q;
                p3    <= mid_q[0];
                p4    <= mid_q[1];
                p5    <= lb1_q;
                p6    <= bot_q[0];
                p7    <= bot_q[1];
                p8    <= in_data;
                out_x <= col_pos - CW'(1);
                out_y <= row_pos - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_window_3x3_linebuf.sv
// tb_window_3x3_linebuf: random-gap raster frames checked every cycle against an image-array model of the window rules.
module tb_window_3x3_linebuf;
    localparam int W  = 64;
    localparam int H  = 64;
    localparam int P  = 13;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [P-1:0]  in_data = '0;
    logic [P-1:0]  p0, p1, p2, p3, p4, p5, p6, p7, p8;
    logic          win_valid, frame_done;
    logic [CW-1:0] out_x, out_y;

    window_3x3_linebuf dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8),
        .win_valid(win_valid), .out_x(out_x), .out_y(out_y), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int img [H][W];
    int mx = 0, my = 0;
    int e_v = 0, e_fd = 0, e_x = 0, e_y = 0;
    int e_p [9];
    int n_v, n_fd, n_x, n_y;
    int n_p [9];
    bit chk_en = 0;
    bit armed = 0;
    int skip = 0;
    int seg_wins = 0, seg_fd = 0;
    int cf [9];
    int cl [9];
    int cfx = 0, cfy = 0, clx = 0, cly = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Compare process: every cycle the outputs are checked, including held values between windows.
    initial forever begin
        int g [9];
        @(negedge clk);
        if (chk_en) begin
            g = '{int'(p0), int'(p1), int'(p2), int'(p3), int'(p4), int'(p5), int'(p6), int'(p7), int'(p8)};
            chk("win_valid", int'(win_valid), e_v);
            chk("frame_done", int'(frame_done), e_fd);
            for (int i = 0; i < 9; i++) chk($sformatf("p%0d", i), g[i], e_p[i]);
            chk("out_x", int'(out_x), e_x);
            chk("out_y", int'(out_y), e_y);
            if (win_valid) begin
                seg_wins++;
                if (skip > 0) skip--;
                else if (armed) begin
                    cf = g; cfx = int'(out_x); cfy = int'(out_y); armed = 0;
                end
            end
            if (frame_done) begin
                seg_fd++;
                cl = g; clx = int'(out_x); cly = int'(out_y);
            end
        end
    end

    // One clock of stimulus; the model places the pixel in the image and derives the next-cycle outputs.
    task automatic cyc(input bit v, input bit sof, input int d);
        in_valid = v;
        in_sof   = sof;
        in_data  = P'(d);
        n_v = 0;
        n_fd = 0;
        if (v) begin
            if (sof) begin mx = 0; my = 0; end
            img[my][mx] = d;
            if (my >= 2 && mx >= 2) begin
                n_v = 1;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        n_p[r*3+c] = img[my-2+r][mx-2+c];
                n_x  = mx - 1;
                n_y  = my - 1;
                n_fd = int'(mx == W-1 && my == H-1);
            end
            mx++;
            if (mx == W) begin
                mx = 0;
                my++;
                if (my == H) my = 0;
            end
        end
        @(posedge clk);
        #1;
        e_v  = n_v;
        e_fd = n_fd;
        if (n_v) begin e_p = n_p; e_x = n_x; e_y = n_y; end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_sof   = 1'b1;
        in_data  = P'($urandom);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        in_sof = 1'b0;
        mx = 0; my = 0;
        e_v = 0; e_fd = 0; e_x = 0; e_y = 0;
        e_p = '{default: 0};
    endtask

    task automatic send_frame(input int offset, input int gap_pct, input bit sof, input int stop);
        for (int i = 0; i < W*H; i++) begin
            if (stop >= 0 && i == stop) break;
            while (int'($urandom_range(99)) < gap_pct) cyc(1'b0, 1'($urandom), int'($urandom));
            cyc(1'b1, sof && i == 0, offset + (i / W) * 64 + i % W);
        end
    endtask

    task automatic seg_begin();
        seg_wins = 0;
        seg_fd = 0;
        armed = 1;
        skip = 0;
    endtask

    task automatic chk_ramp_first(input string tag);
        int ref_p [9] = '{0, 1, 2, 64, 65, 66, 128, 129, 130};
        for (int i = 0; i < 9; i++) chk($sformatf("%s_first_p%0d", tag, i), cf[i], ref_p[i]);
        chk({tag, "_first_x"}, cfx, 1);
        chk({tag, "_first_y"}, cfy, 1);
    endtask

    initial begin
        do_reset();
        chk_en = 1;
        cyc(1'b0, 1'b0, 0);

        // Continuous ramp from reset counters, no sof.
        seg_begin();
        send_frame(0, 0, 1'b0, -1);
        cyc(1'b0, 1'b0, 0);
        cyc(1'b0, 1'b0, 0);
        chk("ramp_wins", seg_wins, 3844);
        chk("ramp_frame_done", seg_fd, 1);
        chk_ramp_first("ramp");
        chk("ramp_last_p8", cl[8], 4095);
        chk("ramp_last_p0", cl[0], 3965);
        chk("ramp_last_x", clx, 62);
        chk("ramp_last_y", cly, 62);

        // Same ramp with ~50% idle cycles.
        seg_begin();
        send_frame(0, 50, 1'b1, -1);
        cyc(1'b0, 1'b0, 0);
        chk("gap_wins", seg_wins, 3844);
        chk("gap_frame_done", seg_fd, 1);
        chk_ramp_first("gap");

        // Back-to-back frames, second offset by 100.
        seg_begin();
        send_frame(0, 0, 1'b1, -1);
        skip = 1;
        armed = 1;
        send_frame(100, 0, 1'b1, -1);
        cyc(1'b0, 1'b0, 0);
        chk("b2b_wins", seg_wins, 2*3844);
        chk("b2b_frame_done", seg_fd, 2);
        chk("b2b_second_p0", cf[0], 100);
        chk("b2b_second_p8", cf[8], 230);

        // Frame aborted by sof at (30,10).
        seg_begin();
        send_frame(0, 20, 1'b1, 10*64+30);
        skip = 1;
        armed = 1;
        send_frame(500, 20, 1'b1, -1);
        cyc(1'b0, 1'b0, 0);
        chk("abort_wins", seg_wins, 524 + 3844);
        chk("abort_frame_done", seg_fd, 1);
        chk("abort_first_x", cfx, 1);
        chk("abort_first_y", cfy, 1);
        chk("abort_first_p0", cf[0], 500);
        chk("abort_first_p8", cf[8], 630);

        // Reset at (20,5), then a fresh frame without sof.
        send_frame(0, 0, 1'b1, 5*64+20);
        do_reset();
        chk("rst_win_valid", int'(win_valid), 0);
        chk("rst_p4", int'(p4), 0);
        chk("rst_out_x", int'(out_x), 0);
        seg_begin();
        send_frame(7, 30, 1'b0, -1);
        cyc(1'b0, 1'b0, 0);
        chk("post_rst_wins", seg_wins, 3844);
        chk("post_rst_frame_done", seg_fd, 1);
        chk("post_rst_first_p8", cf[8], 137);

        cyc(1'b0, 1'b0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/window_3x3_linebuf.md
Name: window_3x3_linebuf

Overview:
- Streaming 3x3 window generator that sits directly upstream of the 3x3 convolution kernels in the 64x64 pipeline.
- Accepts one raster-order pixel per valid cycle and buffers two previous image lines.
- Presents a registered 9-pixel neighbourhood p0..p8 with a valid strobe and centre coordinates, wired straight into the kernel's p0..p8 inputs.
- Emits only interior windows (full neighbourhood available); no border padding.

Parameters:
- IMG_W, 64, image width in pixels (>= 3)
- IMG_H, 64, image height in lines (>= 3)
- PIX_W, 13, pixel width in bits; matches kernel input width
- CW, 7, coordinate counter width; must satisfy 2^CW >= max(IMG_W, IMG_H)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data is a pixel this cycle; no backpressure, accepted whenever high
- in_sof  in  1  qualified by in_valid; marks pixel (0,0) of a frame
- in_data  in  PIX_W  pixel value, raster order
- p0,p1,p2  out  PIX_W each  window top row (line y-2), left to right
- p3,p4,p5  out  PIX_W each  window middle row (line y-1)
- p6,p7,p8  out  PIX_W each  window bottom row (current line y); p8 = newest pixel
- win_valid  out  1  p0..p8 and out_x/out_y valid this cycle (1-cycle pulse per window)
- out_x  out  CW  window centre column
- out_y  out  CW  window centre row
- frame_done  out  1  1-cycle pulse on the last window of a frame

Behaviour:
- Reset (rst=1 at edge): col=0, row=0, win_valid=0, frame_done=0, p0..p8=0, out_x=0, out_y=0. Line-buffer RAM contents are not cleared; they are overwritten before use.
- Counters advance on in_valid only.
  - col increments; at col==IMG_W-1 it wraps to 0 and row increments.
  - At row==IMG_H-1 and col==IMG_W-1, both wrap to 0.
  - No state change on cycles with in_valid=0.
- in_sof with in_valid: the pixel is treated as (0,0) regardless of counters, then counting continues from it. A mid-frame sof aborts the current frame silently (no frame_done).
- Line buffers: two chained delay lines of depth IMG_W.
  - lb1 holds line y-1, lb0 holds line y-2.
  - On each accepted pixel: lb1 output feeds lb0 input; in_data feeds lb1.
  - Three 3-stage horizontal shift registers (one per row) hold the last three columns.
- Window emission:
  - When the accepted pixel has row>=2 and col>=2, the next cycle asserts win_valid=1.
  - p8 = that pixel; p0 = pixel at (row-2, col-2).
  - out_x = col-1, out_y = row-1.
  - Latency: exactly 1 clk from accepting the bottom-right pixel to win_valid.
- Column-wrap rule: windows never straddle lines; pixels with col<2 produce no window.
- Window count: (IMG_W-2)*(IMG_H-2) per frame (3844 at defaults). out_x ranges 1..IMG_W-2, out_y ranges 1..IMG_H-2.
- frame_done: asserted in the same cycle as win_valid for centre (IMG_W-2, IMG_H-2).
- Outputs hold their last value when win_valid=0. Consumers must ignore p0..p8 unless win_valid=1.
- Reset mid-frame: next frame must start with in_sof or from counters at 0. Windows from the first two lines are suppressed by the row>=2 rule, so stale RAM is never emitted.
- Widths: pure data movement; no arithmetic on pixel values. Counters are compared against IMG_W-1 / IMG_H-1 at CW bits.

Decomposition:
- Shared package holds PIX_W, IMG_W, IMG_H, CW defaults and the pixel type; the kernels use the same package.
- One sub-module: line_delay (single-port-per-side shift RAM of depth IMG_W, PIX_W wide, with enable), instantiated twice.
- Counters, shift registers and output registers stay in the top.

Test Plan:
- Ramp frame, in_data=y*64+x, in_valid continuous -> first win_valid 1 cycle after (2,2) is accepted, with p0..p8=0,1,2,64,65,66,128,129,130, out_x=1, out_y=1.
- Same frame -> exactly 3844 win_valid pulses; last window has p8=4095, p0=3965, out_x=62, out_y=62, frame_done=1 in that cycle only.
- Same frame with in_valid randomly low ~50% -> identical window sequence and values; no win_valid during idle gaps.
- Two back-to-back frames (second ramp offset +100) -> no window mixes frames; second frame's first window has p0=100, p8=230.
- in_sof asserted mid-frame at (30,10) -> frame_done never fires for the aborted frame; new frame's first window again at centre (1,1) with correct values.
- rst pulsed at (20,5), then a fresh frame -> all outputs 0 the cycle after reset, and 3844 correct windows follow.
